// File: rtl/cond_unit_if.sv
// cond_unit_if: groups the handshake, instruction, ALU flag and gated-control
// signals of the condition-evaluation stage.
//   master : upstream/downstream side. Drives the instruction, the ALU results
//            and out_ready. Observes in_ready and the registered outputs.
//   slave  : cond_unit side. Drives in_ready, the registered outputs, flags
//            and v_count.
interface cond_unit_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic       alu_n;
    logic       alu_z;
    logic       alu_c;
    logic       alu_v_n;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       no_write;
    logic       out_valid;
    logic       out_ready;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;
    logic [7:0] v_count;

    modport master (
        output in_valid, cond, flag_write, alu_n, alu_z, alu_c, alu_v_n,
               pcs, reg_w, mem_w, no_write, out_ready,
        input  in_ready, out_valid, cond_ex, pc_src, reg_write, mem_write,
               flags, v_count
    );

    modport slave (
        input  in_valid, cond, flag_write, alu_n, alu_z, alu_c, alu_v_n,
               pcs, reg_w, mem_w, no_write, out_ready,
        output in_ready, out_valid, cond_ex, pc_src, reg_write, mem_write,
               flags, v_count
    );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: ARM condition evaluation and NZCV flag register. It evaluates the
// condition field against the architectural flags and registers the gated
// PC-source, register-write and memory-write controls in a one-entry
// valid/ready stage.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : cond_unit_if.slave (instruction in, gated controls out, flags,
//           v_count)
module cond_unit (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);
    logic       out_valid_q, out_valid_d;
    logic       cond_ex_q,   cond_ex_d;
    logic       pc_src_q,    pc_src_d;
    logic       reg_write_q, reg_write_d;
    logic       mem_write_q, mem_write_d;
    logic [3:0] flags_q,     flags_d;     // {N,Z,C,V}
    logic [7:0] v_count_q,   v_count_d;

    logic       in_ready;
    logic       accept;
    logic       ce;
    logic       fn, fz, fc, fv;

    assign in_ready = !out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;
    assign {fn, fz, fc, fv} = flags_q;

    always_comb begin
        ce = 1'b0;
        unique case (bus.cond)
            4'b0000: ce = fz;
            4'b0001: ce = !fz;
            4'b0010: ce = fc;
            4'b0011: ce = !fc;
            4'b0100: ce = fn;
            4'b0101: ce = !fn;
            4'b0110: ce = fv;
            4'b0111: ce = !fv;
            4'b1000: ce = fc & !fz;
            4'b1001: ce = !fc | fz;
            4'b1010: ce = (fn == fv);
            4'b1011: ce = (fn != fv);
            4'b1100: ce = !fz & (fn == fv);
            4'b1101: ce = fz | (fn != fv);
            4'b1110: ce = 1'b1;
            4'b1111: ce = 1'b0;
            default: ce = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        cond_ex_d   = cond_ex_q;
        pc_src_d    = pc_src_q;
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        flags_d     = flags_q;
        v_count_d   = v_count_q;

        if (accept) begin
            out_valid_d = 1'b1;
            cond_ex_d   = ce;
            pc_src_d    = bus.pcs & ce;
            reg_write_d = bus.reg_w & ce & !bus.no_write;
            mem_write_d = bus.mem_w & ce;
            if (ce) begin
                if (bus.flag_write[1]) begin
                    flags_d[3] = bus.alu_n;
                    flags_d[2] = bus.alu_z;
                end
                if (bus.flag_write[0]) begin
                    flags_d[1] = bus.alu_c;
                    flags_d[0] = !bus.alu_v_n;   // overflow input is active-low
                    if (!bus.alu_v_n && v_count_q != 8'hFF) begin
                        v_count_d = v_count_q + 8'd1;
                    end
                end
            end
        end else if (out_valid_q && bus.out_ready) begin
            // Drain with nothing behind it: make sure no stale write strobes linger.
            out_valid_d = 1'b0;
            pc_src_d    = 1'b0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            cond_ex_q   <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            flags_q     <= 4'b0000;
            v_count_q   <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            cond_ex_q   <= cond_ex_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            flags_q     <= flags_d;
            v_count_q   <= v_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.cond_ex   = cond_ex_q;
    assign bus.pc_src    = pc_src_q;
    assign bus.reg_write = reg_write_q;
    assign bus.mem_write = mem_write_q;
    assign bus.flags     = flags_q;
    assign bus.v_count   = v_count_q;
endmodule

// File: doc/cond_unit.md
# cond_unit

Condition-evaluation and flag-register stage for the ARM datapath. It consumes the NZCV results produced by the ALU flag logic and holds the architectural flags. It evaluates each instruction's 4-bit condition field against those flags and emits condition-gated write/branch controls through a one-entry valid/ready pipeline register. It sits between decode/ALU and the register-file / memory write-back controls.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage can accept; = !out_valid | out_ready (combinational).
- cond  in  4  ARM condition field.
- flag_write  in  2  bit1: update N,Z; bit0: update C,V.
- alu_n, alu_z, alu_c  in  1 each  ALU negative / zero / carry, active-high.
- alu_v_n  in  1  ALU overflow, active-low (0 = overflow occurred); inverted internally before use.
- pcs, reg_w, mem_w  in  1 each  ungated PC-source, register-write and memory-write requests.
- no_write  in  1  suppresses reg_write (CMP/TST class).
- out_valid  out  1  registered output holds an instruction.
- out_ready  in  1  downstream accepts.
- cond_ex  out  1  registered condition result for the held instruction.
- pc_src, reg_write, mem_write  out  1 each  registered gated controls.
- flags  out  4  architectural {N,Z,C,V}.
- v_count  out  8  saturating count of flag writes that set V=1.

## Operation
- Accept = in_valid & in_ready. Nothing changes state without accept, except reset.
- On accept, compute ce from cond and the current flags register:
  - 0000 EQ Z; 0001 NE !Z.
  - 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N.
  - 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 NV 0.
- On accept, the output register loads:
  - cond_ex=ce.
  - pc_src=pcs&ce.
  - reg_write=reg_w&ce&!no_write.
  - mem_write=mem_w&ce.
  - out_valid=1.
- Flag update on accept when ce=1:
  - flag_write[1] loads N,Z from alu_n, alu_z.
  - flag_write[0] loads C from alu_c and V from !alu_v_n.
  - With ce=0, flags are unchanged regardless of flag_write.
- v_count increments by 1 on any accept with ce & flag_write[0] & !alu_v_n. It saturates at 255 and never wraps.
- Output drain:
  - out_valid & out_ready & !accept clears out_valid. Gated controls drop to 0 on that same edge.
  - Simultaneous drain and accept loads the new instruction; out_valid stays 1.
- While out_valid=1 and out_ready=0:
  - in_ready=0.
  - Output register and flags hold; inputs are ignored.

## Timing
- Reset (reset=0, asynchronous):
  - flags=0000, v_count=0, out_valid=0.
  - cond_ex, pc_src, reg_write, mem_write = 0.
  - Takes effect without a clock edge. A mid-stall reset discards the held instruction.
- Latency: 1 cycle. Inputs accepted at edge k appear on the outputs after edge k.
- Flags update at the accept edge. An instruction accepted at edge k+1 sees the flags written at edge k, so back-to-back flag-dependent instructions need no bypass.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready is a pure function of registered out_valid and out_ready, with no path from in_valid.
- flags and v_count are direct register outputs.

## Test plan
- Reset, then CMP-equal: reset low mid-stream → every output 0 at once. Then accept flag_write=11, alu_z=1, alu_v_n=1, cond=1110 → next cycle flags=0100, cond_ex=1.
- Full condition sweep: for each of the 16 flag combos × 16 cond codes, accept with flag_write=00 → cond_ex matches the table. NV always gives 0, AL always gives 1.
- Overflow polarity and count:
  - Accept flag_write=01, alu_v_n=0, cond=AL → V=1, v_count=1.
  - Same with alu_v_n=1 → V=0, v_count stays 1.
  - 300 overflow writes → v_count=255.
- Failed condition:
  - With flags Z=0, accept cond=EQ, reg_w=1, mem_w=1, pcs=1, flag_write=11 → all gated controls 0, flags unchanged.
  - no_write=1 with cond=AL, reg_w=1 → reg_write=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs and flags frozen.
  - Release → held instruction drains and the next one loads on the same edge, out_valid continuous.
- Back-to-back dependency: accept SUBS with alu_n=1 and alu_v_n=1, then BLT with pcs=1 on the next cycle → pc_src=1.
